muldiv_arbiter: RTL and testbench
=================================

# muldiv_arbiter

Shares the single iterative multiply/divide unit in the EX stage between two requesters (main pipeline slot 0 and an auxiliary slot 1). Accepts one operation at a time through a valid/ready handshake, latches its operands, drives the unit until its result is ready, releases the unit back to its idle state, and returns HI/LO to the requester that owns the operation. Flush aborts any in-flight operation without producing a response.

## Interface
- FUNC_W, 5: width of the unit function code
- FUNC_NONE, 0: code driven when the unit is idle
- FUNC_MUL, 1: multiply code
- FUNC_DIV, 2: divide code
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- flush  in  1  abort in-flight operation and any pending response
- reqN_valid  in  1  (N = 0, 1) request present
- reqN_ready  out  1  request accepted this cycle (pulse)
- reqN_op  in  1  0 = multiply, 1 = divide
- reqN_sign  in  1  signed operation
- reqN_a / reqN_b  in  32  operands (a = dividend/multiplicand)
- rspN_valid  out  1  result available for requester N
- rspN_ready  in  1  requester consumes result
- rspN_hi / rspN_lo  out  32  result (div: hi = remainder, lo = quotient)
- unit_func  out  FUNC_W  function code to unit
- unit_sign / unit_a / unit_b  out  1/32/32  operands to unit
- unit_hold  out  1  keeps unit in its done state while high
- unit_flush  out  1  unit abort
- unit_busy  in  1  unit result not yet ready (combinational from unit)
- unit_hi / unit_lo  in  32  unit result registers

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: unit_func = FUNC_NONE. If any reqN_valid, grant one. Assert its reqN_ready for that cycle, latch op/sign/a/b and owner id, and go to ISSUE.
- ISSUE: unit_func = FUNC_MUL/FUNC_DIV from the latched op. unit_sign/a/b come from the latch and are held stable. unit_hold = 0.
  - When unit_busy = 0 in ISSUE: capture unit_hi/unit_lo into the result registers and go to RESP. unit_hold = 0 in that cycle releases the unit.
- RESP: unit_func = FUNC_NONE, which prevents a restart. rsp<owner>_valid = 1 with the captured hi/lo; the other rsp valid stays 0. On rsp<owner>_ready = 1, go to IDLE.
- unit_hold is 1 only in RESP; in every other state it is 0.
- flush, in any state, takes priority:
  - unit_flush = flush, combinational pass-through.
  - Next state is IDLE. The captured result is discarded and no rspN_valid is asserted.
  - reqN_ready is suppressed in a flush cycle.
- Outputs during and after reset: reqN_ready = 0, rspN_valid = 0, rspN_hi/lo = 0, unit_func = FUNC_NONE, unit_a/b = 0, unit_sign = 0, unit_hold = 0, state = IDLE, round-robin pointer favours requester 0.
- Reset mid-operation abandons the operation. The unit is reset by the same rst.

## Timing
- Request accepted at edge T (IDLE, valid). ISSUE begins in cycle T+1.
- Result captured in the first ISSUE cycle with unit_busy = 0. rsp valid from the next cycle.
- rspN_valid holds until consumed; there is no timeout.
- Next request is accepted earliest in the cycle after rsp consumption. IDLE is never skipped.
- reqN_valid is level-sensitive. A requester holds its operands until it sees reqN_ready.
- A new request and a response to the same requester may not overlap, because a single operation is in flight.

## Configuration
- MDU_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant the one not granted last.
  - The pointer updates on each grant.
- Undefined: fixed priority. Requester 0 always wins a tie, and the pointer logic is removed.

## Test plan
- req0 unsigned mul a=3, b=5 → req0_ready pulse, unit_func = FUNC_MUL until unit_busy falls, then rsp0_valid with hi = 0, lo = 15; rsp1_valid stays 0.
- req1 signed div a = 0xFFFFFFF9 (−7), b = 2 → rsp1_lo = 0xFFFFFFFD, rsp1_hi = 0xFFFFFFFF; unit_func = FUNC_NONE in every RESP cycle.
- req0 and req1 both valid every cycle for 4 operations:
  - With MDU_ARB_RR_EN: grants alternate 0, 1, 0, 1.
  - Without it: grants are 0, 0, 0, 0 and req1 never granted while req0 valid.
- rsp0_ready held low for 10 cycles → rsp0_valid, hi and lo stable for all 10 cycles, unit_hold = 1, no new grant; grant occurs the cycle after consumption.
- flush asserted in the third ISSUE cycle of a divide → unit_flush = 1 that cycle, state IDLE next cycle, no rsp asserted, and the following mul 2×2 returns lo = 4.
- rst pulsed asynchronously mid-ISSUE → all outputs at reset values immediately; the next request completes correctly.

Source files
------------

// File: rtl/muldiv_arbiter.sv
// Two-requester front end for the shared iterative multiply/divide unit in EX.
// Define MDU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module muldiv_arbiter #(
  parameter int                FUNC_W    = 5,
  parameter logic [FUNC_W-1:0] FUNC_NONE = FUNC_W'(0),
  parameter logic [FUNC_W-1:0] FUNC_MUL  = FUNC_W'(1),
  parameter logic [FUNC_W-1:0] FUNC_DIV  = FUNC_W'(2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_op,
  input  logic              req0_sign,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_op,
  input  logic              req1_sign,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_hi,
  output logic [31:0]       rsp0_lo,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_hi,
  output logic [31:0]       rsp1_lo,
  output logic [FUNC_W-1:0] unit_func,
  output logic              unit_sign,
  output logic [31:0]       unit_a,
  output logic [31:0]       unit_b,
  output logic              unit_hold,
  output logic              unit_flush,
  input  logic              unit_busy,
  input  logic [31:0]       unit_hi,
  input  logic [31:0]       unit_lo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        owner;
  logic        op_lat;
  logic        sign_lat;
  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        take;
  logic        grant_id;
  logic        capture;
  logic        owner_ready;

  // A grant happens only in IDLE, never during flush or while reset is held.
  assign take    = (state == IDLE) && (req0_valid || req1_valid) && !flush && !rst;
  assign capture = (state == ISSUE) && !unit_busy && !flush;

`ifdef MDU_ARB_RR_EN
  logic last_grant;

  always_comb begin
    grant_id = !req0_valid;
    if (req0_valid && req1_valid) begin
      grant_id = !last_grant;
    end
  end

  // Reset to 1 so the first tie goes to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (take) begin
      last_grant <= grant_id;
    end
  end
`else
  assign grant_id = !req0_valid;
`endif

  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = ISSUE;
      ISSUE:   if (!unit_busy) state_next = RESP;
      RESP:    if (owner_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      op_lat   <= 1'b0;
      sign_lat <= 1'b0;
      a_lat    <= 32'd0;
      b_lat    <= 32'd0;
    end else if (take) begin
      owner    <= grant_id;
      op_lat   <= grant_id ? req1_op   : req0_op;
      sign_lat <= grant_id ? req1_sign : req0_sign;
      a_lat    <= grant_id ? req1_a    : req0_a;
      b_lat    <= grant_id ? req1_b    : req0_b;
    end
  end

  // Flush drops any captured result so it can never leak into a later response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_res <= 32'd0;
      lo_res <= 32'd0;
    end else if (flush) begin
      hi_res <= 32'd0;
      lo_res <= 32'd0;
    end else if (capture) begin
      hi_res <= unit_hi;
      lo_res <= unit_lo;
    end
  end

  always_comb begin
    unit_func = FUNC_NONE;
    if (state == ISSUE) begin
      unit_func = op_lat ? FUNC_DIV : FUNC_MUL;
    end
  end

  assign unit_sign  = sign_lat;
  assign unit_a     = a_lat;
  assign unit_b     = b_lat;
  assign unit_hold  = (state == RESP);
  assign unit_flush = flush;

  assign req0_ready = take && !grant_id;
  assign req1_ready = take && grant_id;

  assign rsp0_valid = (state == RESP) && !owner && !flush;
  assign rsp1_valid = (state == RESP) && owner && !flush;
  assign rsp0_hi    = hi_res;
  assign rsp0_lo    = lo_res;
  assign rsp1_hi    = hi_res;
  assign rsp1_lo    = lo_res;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Self-checking bench for muldiv_arbiter with an ideal iterative unit model and a
// scoreboard computed from plain arithmetic; follows MDU_ARB_RR_EN when defined.
module tb_muldiv_arbiter;

  localparam logic [4:0] F_NONE = 5'd0;
  localparam logic [4:0] F_MUL  = 5'd1;
  localparam logic [4:0] F_DIV  = 5'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req0_op = 1'b0, req0_sign = 1'b0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0;
  logic        req1_valid = 1'b0, req1_op = 1'b0, req1_sign = 1'b0;
  logic [31:0] req1_a = 32'd0, req1_b = 32'd0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_hi, rsp0_lo, rsp1_hi, rsp1_lo;
  logic [4:0]  unit_func;
  logic        unit_sign, unit_hold, unit_flush, unit_busy;
  logic [31:0] unit_a, unit_b, unit_hi, unit_lo;

  int errors = 0;
  int checks = 0;
  int last_grant = 1;
  int u_lat = 3;

  muldiv_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_sign(req0_sign), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_sign(req1_sign), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_hi(rsp0_hi), .rsp0_lo(rsp0_lo),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_hi(rsp1_hi), .rsp1_lo(rsp1_lo),
    .unit_func(unit_func), .unit_sign(unit_sign), .unit_a(unit_a), .unit_b(unit_b),
    .unit_hold(unit_hold), .unit_flush(unit_flush), .unit_busy(unit_busy),
    .unit_hi(unit_hi), .unit_lo(unit_lo)
  );

  always #5 clk = ~clk;

  // Plain arithmetic: mul -> {hi,lo} = a*b; div -> {hi,lo} = {a%b, a/b}.
  function automatic logic [63:0] mdu_math(input logic op, input logic sign,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, sp;
    logic signed [31:0] sa, sb, sq, sr;
    if (!op) begin
      if (sign) begin
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sp = sa64 * sb64;
        return sp;
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (sign) begin
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  function automatic int exp_grant(input logic v0, input logic v1);
`ifdef MDU_ARB_RR_EN
    if (v0 && v1) return (last_grant == 0) ? 1 : 0;
`endif
    return v0 ? 0 : 1;
  endfunction

  // Ideal unit: busy for u_lat cycles after a function appears, then holds its result
  // until it is neither held nor given a function.
  int          u_cnt;
  logic        u_done;
  logic [31:0] u_hi, u_lo;
  assign unit_busy = (unit_func != F_NONE) && !u_done;
  assign unit_hi = u_hi;
  assign unit_lo = u_lo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_cnt <= 0; u_done <= 1'b0; u_hi <= 32'd0; u_lo <= 32'd0;
    end else if (unit_flush) begin
      u_cnt <= 0; u_done <= 1'b0;
    end else if (u_done) begin
      if (!unit_hold && unit_func == F_NONE) u_done <= 1'b0;
    end else if (unit_func != F_NONE) begin
      if (u_cnt >= u_lat - 1) begin
        u_done <= 1'b1;
        u_cnt <= 0;
        {u_hi, u_lo} <= mdu_math(unit_func == F_DIV, unit_sign, unit_a, unit_b);
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  task automatic drive_req(input int id, input logic op, input logic sign,
                           input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_sign = sign; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_sign = sign; req1_a = a; req1_b = b;
    end
  endtask

  // Called at a falling edge; returns at the falling edge inside the first ISSUE cycle.
  task automatic await_grant(output int gid, output int waited, output logic both,
                             output logic to);
    to = 1'b1; gid = -1; waited = 0; both = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        gid = req0_ready ? 0 : 1;
        both = req0_ready && req1_ready;
        to = 1'b0;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (!to) begin
      @(negedge clk);
      if (gid == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  // Watches ISSUE until the response shows up, then holds it for 'delay' cycles before
  // consuming it; flags any misbehaviour seen in ISSUE or RESP cycles.
  task automatic await_rsp(input int id, input int delay, input logic [4:0] exp_func,
                           output logic [31:0] hi, output logic [31:0] lo, output int n_issue,
                           output logic to, output logic bad_issue, output logic bad_resp);
    logic mine, other;
    to = 1'b1; bad_issue = 1'b0; bad_resp = 1'b0; n_issue = 0; hi = '0; lo = '0;
    for (int i = 0; i < 200; i++) begin
      #1;
      mine = (id == 0) ? rsp0_valid : rsp1_valid;
      if (mine) begin to = 1'b0; break; end
      if (unit_func !== exp_func || unit_hold !== 1'b0 || rsp0_valid || rsp1_valid)
        bad_issue = 1'b1;
      n_issue++;
      @(negedge clk);
    end
    if (!to) begin
      hi = (id == 0) ? rsp0_hi : rsp1_hi;
      lo = (id == 0) ? rsp0_lo : rsp1_lo;
      for (int k = 0; k <= delay; k++) begin
        if (k > 0) begin @(negedge clk); #1; end
        mine  = (id == 0) ? rsp0_valid : rsp1_valid;
        other = (id == 0) ? rsp1_valid : rsp0_valid;
        if (mine !== 1'b1 || other !== 1'b0 || unit_hold !== 1'b1 || unit_func !== F_NONE ||
            req0_ready || req1_ready ||
            ((id == 0) ? {rsp0_hi, rsp0_lo} : {rsp1_hi, rsp1_lo}) !== {hi, lo})
          bad_resp = 1'b1;
        if (k == delay) begin
          if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        end
      end
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    drive_req(0, 1'b0, 1'b0, 32'd9, 32'd9);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_hi, rsp0_lo, rsp1_hi, rsp1_lo,
         unit_func, unit_sign, unit_a, unit_b, unit_hold} !== '0)
      begin errors++; $display("FAIL reset_during: outputs not all zero (ready0=%b func=%0d a=%h)", req0_ready, unit_func, unit_a); end
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, unit_func, unit_hold, unit_a} !== '0)
      begin errors++; $display("FAIL reset_after: outputs not idle (func=%0d hold=%b)", unit_func, unit_hold); end
    $display("reset: done");
  endtask

  task automatic test_mul_basic();
    int gid, waited, n; logic both, to, bi, br; logic [31:0] hi, lo;
    @(negedge clk);
    u_lat = 3;
    drive_req(0, 1'b0, 1'b0, 32'd3, 32'd5);
    await_grant(gid, waited, both, to);
    checks++;
    if (to || gid != 0 || both || waited != 0)
      begin errors++; $display("FAIL mul_grant: got gid=%0d waited=%0d both=%b, expected gid=0 waited=0", gid, waited, both); end
    last_grant = 0;
    await_rsp(0, 0, F_MUL, hi, lo, n, to, bi, br);
    checks++;
    if (to || hi !== 32'd0 || lo !== 32'd15)
      begin errors++; $display("FAIL mul_result: got hi=%h lo=%h to=%b, expected hi=0 lo=f", hi, lo, to); end
    checks++;
    if (bi || br || n != u_lat + 1)
      begin errors++; $display("FAIL mul_timing: bad_issue=%b bad_resp=%b issue_cycles=%0d expected %0d", bi, br, n, u_lat + 1); end
    $display("mul 3*5: hi=%h lo=%h issue_cycles=%0d", hi, lo, n);
  endtask

  task automatic test_div_signed();
    int gid, waited, n; logic both, to, bi, br; logic [31:0] hi, lo;
    @(negedge clk);
    u_lat = 5;
    drive_req(1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    await_grant(gid, waited, both, to);
    checks++;
    if (to || gid != 1 || both)
      begin errors++; $display("FAIL div_grant: got gid=%0d, expected 1", gid); end
    last_grant = 1;
    await_rsp(1, 3, F_DIV, hi, lo, n, to, bi, br);
    checks++;
    if (to || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      begin errors++; $display("FAIL div_result: got hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi, lo); end
    checks++;
    if (bi || br || n != u_lat + 1)
      begin errors++; $display("FAIL div_resp_cycles: bad_issue=%b bad_resp=%b issue_cycles=%0d", bi, br, n); end
    $display("div -7/2 signed: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_arbitration();
    int gid, waited, n, eg; logic both, to, bi, br; logic [31:0] hi, lo;
    logic [31:0] a0, b0, a1, b1;
    @(negedge clk);
    u_lat = 2;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    drive_req(0, 1'b0, 1'b0, a0, b0);
    drive_req(1, 1'b0, 1'b1, a1, b1);
    for (int k = 0; k < 4; k++) begin
      eg = exp_grant(1'b1, 1'b1);
      await_grant(gid, waited, both, to);
      checks++;
      if (to || gid != eg || both)
        begin errors++; $display("FAIL arb_grant%0d: got %0d, expected %0d", k, gid, eg); end
      if (to) break;
      last_grant = gid;
      await_rsp(gid, 0, F_MUL, hi, lo, n, to, bi, br);
      checks++;
      if (to || {hi, lo} !== ((gid == 0) ? mdu_math(1'b0, 1'b0, a0, b0) : mdu_math(1'b0, 1'b1, a1, b1)) || bi || br)
        begin errors++; $display("FAIL arb_result%0d: got %h_%h for requester %0d", k, hi, lo, gid); end
      $display("arb op %0d: granted %0d result %h_%h", k, gid, hi, lo);
      if (gid == 0) begin a0 = $urandom; b0 = $urandom; drive_req(0, 1'b0, 1'b0, a0, b0); end
      else begin a1 = $urandom; b1 = $urandom; drive_req(1, 1'b0, 1'b1, a1, b1); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int gid, waited, n; logic both, to, bi, br; logic [31:0] hi, lo, a, b;
    @(negedge clk);
    u_lat = 4;
    a = $urandom; b = $urandom;
    drive_req(0, 1'b0, 1'b1, a, b);
    await_grant(gid, waited, both, to);
    last_grant = 0;
    drive_req(1, 1'b0, 1'b0, 32'd7, 32'd6);
    await_rsp(0, 10, F_MUL, hi, lo, n, to, bi, br);
    checks++;
    if (to || gid != 0 || {hi, lo} !== mdu_math(1'b0, 1'b1, a, b))
      begin errors++; $display("FAIL bp_result: got %h_%h gid=%0d, expected %h", hi, lo, gid, mdu_math(1'b0, 1'b1, a, b)); end
    checks++;
    if (bi || br)
      begin errors++; $display("FAIL bp_hold: bad_issue=%b bad_resp=%b over 10 stalled cycles", bi, br); end
    await_grant(gid, waited, both, to);
    checks++;
    if (to || gid != 1 || waited != 0)
      begin errors++; $display("FAIL bp_next_grant: got gid=%0d waited=%0d, expected gid=1 waited=0", gid, waited); end
    last_grant = 1;
    await_rsp(1, 0, F_MUL, hi, lo, n, to, bi, br);
    checks++;
    if (to || hi !== 32'd0 || lo !== 32'd42)
      begin errors++; $display("FAIL bp_second: got hi=%h lo=%h, expected 0 / 2a", hi, lo); end
    $display("backpressure: stall held 10 cycles, follow-up lo=%h", lo);
  endtask

  task automatic test_flush();
    int gid, waited, n; logic both, to, bi, br; logic [31:0] hi, lo;
    @(negedge clk);
    u_lat = 8;
    drive_req(0, 1'b1, 1'b0, 32'd100, 32'd7);
    await_grant(gid, waited, both, to);
    last_grant = 0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (unit_flush !== 1'b1 || unit_func !== F_DIV || rsp0_valid || rsp1_valid)
      begin errors++; $display("FAIL flush_cycle: unit_flush=%b func=%0d, expected 1 and %0d", unit_flush, unit_func, F_DIV); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (unit_func !== F_NONE || unit_flush !== 1'b0 || rsp0_valid || rsp1_valid || unit_hold)
      begin errors++; $display("FAIL flush_after: func=%0d rsp0=%b rsp1=%b, expected idle", unit_func, rsp0_valid, rsp1_valid); end
    u_lat = 2;
    drive_req(0, 1'b0, 1'b0, 32'd2, 32'd2);
    await_grant(gid, waited, both, to);
    checks++;
    if (to || gid != 0 || waited != 0)
      begin errors++; $display("FAIL flush_regrant: gid=%0d waited=%0d, expected immediate grant", gid, waited); end
    last_grant = 0;
    await_rsp(0, 0, F_MUL, hi, lo, n, to, bi, br);
    checks++;
    if (to || hi !== 32'd0 || lo !== 32'd4 || bi)
      begin errors++; $display("FAIL flush_mul: got hi=%h lo=%h, expected 0 / 4", hi, lo); end
    $display("flush: aborted divide, then 2*2 lo=%h", lo);
  endtask

  task automatic test_async_reset();
    int gid, waited, n, eg; logic both, to, bi, br; logic [31:0] hi, lo, a, b;
    @(negedge clk);
    u_lat = 6;
    drive_req(1, 1'b0, 1'b0, 32'h1234, 32'h55);
    await_grant(gid, waited, both, to);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_hi, rsp0_lo, rsp1_hi, rsp1_lo,
         unit_func, unit_sign, unit_a, unit_b, unit_hold} !== '0)
      begin errors++; $display("FAIL async_reset: outputs not zero (func=%0d a=%h b=%h)", unit_func, unit_a, unit_b); end
    @(negedge clk);
    rst = 1'b0;
    last_grant = 1;
    a = $urandom; b = $urandom_range(1, 5000);
    drive_req(0, 1'b1, 1'b0, a, b);
    drive_req(1, 1'b0, 1'b0, 32'd3, 32'd3);
    eg = exp_grant(1'b1, 1'b1);
    await_grant(gid, waited, both, to);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (to || gid != eg)
      begin errors++; $display("FAIL post_reset_grant: got %0d, expected %0d", gid, eg); end
    if (!to) begin
      last_grant = gid;
      await_rsp(gid, 1, (gid == 0) ? F_DIV : F_MUL, hi, lo, n, to, bi, br);
      checks++;
      if (to || bi || br || {hi, lo} !== ((gid == 0) ? mdu_math(1'b1, 1'b0, a, b) : 64'd9))
        begin errors++; $display("FAIL post_reset_result: got %h_%h from requester %0d", hi, lo, gid); end
    end
    $display("async reset: recovered, result %h_%h", hi, lo);
  endtask

  task automatic test_random();
    int gid, waited, n, eg, dly; logic both, to, bi, br; logic [31:0] hi, lo;
    logic v0, v1;
    logic op_t[2]; logic sg_t[2]; logic [31:0] a_t[2]; logic [31:0] b_t[2];
    logic [63:0] expv;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      for (int id = 0; id < 2; id++) begin
        op_t[id] = 1'($urandom_range(0, 1)); sg_t[id] = 1'($urandom_range(0, 1));
        a_t[id] = $urandom; b_t[id] = $urandom;
        if ($urandom_range(0, 1) == 1) b_t[id] = $urandom_range(1, 300);
        if (b_t[id] == 32'd0) b_t[id] = 32'd1;
        if (a_t[id] == 32'h8000_0000 && b_t[id] == 32'hFFFF_FFFF) b_t[id] = 32'd3;
      end
      if (v0) drive_req(0, op_t[0], sg_t[0], a_t[0], b_t[0]);
      if (v1) drive_req(1, op_t[1], sg_t[1], a_t[1], b_t[1]);
      u_lat = $urandom_range(1, 6);
      dly = $urandom_range(0, 3);
      eg = exp_grant(v0, v1);
      await_grant(gid, waited, both, to);
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (to || gid != eg || waited != 0 || both)
        begin errors++; $display("FAIL rnd_grant%0d: got %0d waited=%0d, expected %0d", t, gid, waited, eg); end
      if (to) break;
      last_grant = gid;
      expv = mdu_math(op_t[gid], sg_t[gid], a_t[gid], b_t[gid]);
      await_rsp(gid, dly, op_t[gid] ? F_DIV : F_MUL, hi, lo, n, to, bi, br);
      checks++;
      if (to || {hi, lo} !== expv || bi || br || n != u_lat + 1)
        begin errors++; $display("FAIL rnd_op%0d: got %h_%h n=%0d, expected %h n=%0d", t, hi, lo, n, expv, u_lat + 1); end
      $display("rnd %0d: req%0d %s%s a=%h b=%h -> %h_%h", t, gid, op_t[gid] ? "div" : "mul",
               sg_t[gid] ? "s" : "u", a_t[gid], b_t[gid], hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_signed();
    test_arbitration();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
